// File: rtl/auth_ctrl.sv
// Code-lock controller: stores a 4-bit code, checks guesses, and locks out after repeated failures.
// Result pulses appear one cycle after the CHECK state; guesses are accepted only while ARMED.
module auth_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [3:0] set_code,
  input  logic       guess_valid,
  input  logic [3:0] guess_code,
  input  logic       relock,
  output logic       guess_ready,
  output logic       matched,
  output logic       unmatched,
  output logic       locked,
  output logic       is_open,
  output logic [1:0] attempts_left
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_OPEN    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam logic [2:0] MAX_W   = 3'(MAX_TRIES);
  localparam logic [7:0] LOCK_W  = 8'(LOCKOUT_CYCLES);

  logic [2:0] state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [3:0] guess_q, guess_d;
  logic [1:0] fail_q, fail_d;
  logic [7:0] timer_q, timer_d;
  logic       matched_q, matched_d;
  logic       unmatched_q, unmatched_d;

  logic [2:0] fail_inc;
  logic       code_eq;

  assign fail_inc = {1'b0, fail_q} + 3'd1;
  assign code_eq  = &(~(guess_q ^ code_q));

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    guess_d     = guess_q;
    fail_d      = fail_q;
    timer_d     = timer_q;
    matched_d   = 1'b0;
    unmatched_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (set_en) begin
          code_d  = set_code;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (guess_valid) begin
          guess_d = guess_code;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (code_eq) begin
          matched_d = 1'b1;
          fail_d    = 2'd0;
          state_d   = ST_OPEN;
        end else begin
          unmatched_d = 1'b1;
          fail_d      = fail_inc[1:0];
          if (fail_inc < MAX_W) begin
            state_d = ST_ARMED;
          end else begin
            timer_d = LOCK_W;
            state_d = ST_LOCKOUT;
          end
        end
      end
      ST_OPEN: begin
        // A new code wins over a plain relock when both arrive together.
        if (set_en) begin
          code_d  = set_code;
          state_d = ST_ARMED;
        end else if (relock) begin
          state_d = ST_ARMED;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q <= 8'd1) begin
          timer_d = 8'd0;
          fail_d  = 2'd0;
          state_d = ST_ARMED;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= 4'd0;
      guess_q     <= 4'd0;
      fail_q      <= 2'd0;
      timer_q     <= 8'd0;
      matched_q   <= 1'b0;
      unmatched_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      guess_q     <= guess_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      matched_q   <= matched_d;
      unmatched_q <= unmatched_d;
    end
  end

  // Failure count sits at MAX_TRIES during lockout, so attempts_left reads 0 there.
  assign guess_ready   = (state_q == ST_ARMED);
  assign locked        = (state_q == ST_LOCKOUT);
  assign is_open       = (state_q == ST_OPEN);
  assign matched       = matched_q;
  assign unmatched     = unmatched_q;
  assign attempts_left = MAX_W[1:0] - fail_q;

endmodule

// File: tb/tb_auth_ctrl.sv
// Bench for auth_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_auth_ctrl;
  localparam int MAX = 3;
  localparam int LC  = 16;

  logic       clk = 1'b0;
  logic       rst, set_en, guess_valid, relock;
  logic [3:0] set_code, guess_code;
  logic       guess_ready, matched, unmatched, locked, is_open;
  logic [1:0] attempts_left;

  auth_ctrl #(.MAX_TRIES(MAX), .LOCKOUT_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .set_en(set_en), .set_code(set_code),
    .guess_valid(guess_valid), .guess_code(guess_code), .relock(relock),
    .guess_ready(guess_ready), .matched(matched), .unmatched(unmatched),
    .locked(locked), .is_open(is_open), .attempts_left(attempts_left)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_ARMED, M_CHECK, M_OPEN, M_LOCK} mode_t;
  mode_t mode;
  int    code, g, fails, lock_left, res;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; code = 0; g = 0; fails = 0; lock_left = 0; res = -1;
  endtask

  // One clock edge of the reference behaviour; res holds the pulse for the following cycle.
  task automatic model_edge(input bit se, input int sc, input bit gv, input int gc, input bit rl);
    res = -1;
    case (mode)
      M_IDLE:  if (se) begin code = sc; mode = M_ARMED; end
      M_ARMED: if (gv) begin g = gc; mode = M_CHECK; end
      M_CHECK: begin
        if (g == code) begin
          res = 1; fails = 0; mode = M_OPEN;
        end else begin
          res = 0; fails = fails + 1;
          if (fails >= MAX) begin mode = M_LOCK; lock_left = LC; end
          else mode = M_ARMED;
        end
      end
      M_OPEN: begin
        if (se) begin code = sc; mode = M_ARMED; end
        else if (rl) mode = M_ARMED;
      end
      M_LOCK: begin
        lock_left = lock_left - 1;
        if (lock_left == 0) begin fails = 0; mode = M_ARMED; end
      end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check("guess_ready", 32'(guess_ready), 32'(mode == M_ARMED));
    check("matched", 32'(matched), 32'(res == 1));
    check("unmatched", 32'(unmatched), 32'(res == 0));
    check("locked", 32'(locked), 32'(mode == M_LOCK));
    check("is_open", 32'(is_open), 32'(mode == M_OPEN));
    check("attempts_left", 32'(attempts_left), (mode == M_LOCK) ? 32'd0 : 32'(MAX - fails));
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic step(input bit se, input logic [3:0] sc, input bit gv, input logic [3:0] gc,
                      input bit rl);
    set_en = se; set_code = sc; guess_valid = gv; guess_code = gc; relock = rl;
    @(posedge clk);
    model_edge(se, int'(sc), gv, int'(gc), rl);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic guess_and_result(input logic [3:0] gc);
    step(1'b0, 4'd0, 1'b1, gc, 1'b0);
    idle_step();
  endtask

  task automatic pulse_reset();
    set_en = 0; guess_valid = 0; relock = 0; set_code = 0; guess_code = 0;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lock_cnt;
    bit se, gv, rl;
    logic [3:0] sc, gc;

    rst = 1'b1; set_en = 0; guess_valid = 0; relock = 0; set_code = 0; guess_code = 0;
    model_reset();
    #1;
    check_outputs();
    check("reset_attempts", 32'(attempts_left), 32'd3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Set code and guess it right.
    step(1'b1, 4'b1010, 1'b0, 4'd0, 1'b0);
    check("ready_after_set", 32'(guess_ready), 32'd1);
    step(1'b0, 4'd0, 1'b1, 4'b1010, 1'b0);
    check("no_pulse_in_check", 32'(matched | unmatched), 32'd0);
    idle_step();
    check("match_pulse", 32'(matched), 32'd1);
    check("open_after_match", 32'(is_open), 32'd1);
    check("attempts_open", 32'(attempts_left), 32'd3);
    idle_step();
    check("match_one_cycle", 32'(matched), 32'd0);

    // Two misses then a hit.
    step(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0);
    guess_and_result(4'b0111);
    check("miss1_pulse", 32'(unmatched), 32'd1);
    check("miss1_attempts", 32'(attempts_left), 32'd2);
    guess_and_result(4'b0100);
    check("miss2_attempts", 32'(attempts_left), 32'd1);
    check("miss2_armed", 32'(guess_ready), 32'd1);
    guess_and_result(4'b0110);
    check("hit_after_miss", 32'(matched), 32'd1);
    check("hit_attempts", 32'(attempts_left), 32'd3);

    // Three misses into lockout, guesses during lockout ignored.
    step(1'b1, 4'b1111, 1'b0, 4'd0, 1'b0);
    guess_and_result(4'b0000);
    guess_and_result(4'b0001);
    step(1'b0, 4'd0, 1'b1, 4'b0010, 1'b0);
    idle_step();
    check("lock_unmatched", 32'(unmatched), 32'd1);
    lock_cnt = locked ? 1 : 0;
    for (int i = 0; i < LC - 1; i++) begin
      step(1'b0, 4'd0, 1'b1, 4'b1111, 1'b0);
      if (locked) lock_cnt++;
    end
    idle_step();
    if (locked) lock_cnt++;
    check("lock_duration", 32'(lock_cnt), 32'(LC));
    check("armed_after_lock", 32'(guess_ready), 32'd1);
    check("attempts_after_lock", 32'(attempts_left), 32'd3);

    // IDLE ignores guesses; ARMED ignores set_en.
    pulse_reset();
    step(1'b0, 4'd0, 1'b1, 4'b0000, 1'b0);
    check("idle_no_pulse", 32'(matched | unmatched), 32'd0);
    check("idle_not_ready", 32'(guess_ready), 32'd0);
    step(1'b1, 4'b0101, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 4'd0, 1'b0);
    guess_and_result(4'b0101);
    check("armed_set_ignored", 32'(matched), 32'd1);

    // set_en beats relock in OPEN.
    step(1'b1, 4'b0011, 1'b0, 4'd0, 1'b1);
    check("open_set_relock", 32'(guess_ready), 32'd1);
    guess_and_result(4'b0011);
    check("new_code_match", 32'(matched), 32'd1);

    // Reset during lockout cycle 5 and during CHECK.
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    guess_and_result(4'b0000);
    guess_and_result(4'b0000);
    step(1'b0, 4'd0, 1'b1, 4'b0000, 1'b0);
    idle_step();
    for (int i = 0; i < 4; i++) idle_step();
    check("in_lock_before_rst", 32'(locked), 32'd1);
    pulse_reset();
    check("rst_lock_attempts", 32'(attempts_left), 32'd3);
    step(1'b1, 4'b1001, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'b1001, 1'b0);
    pulse_reset();
    idle_step();
    check("rst_check_no_pulse", 32'(matched), 32'd0);
    check("rst_check_idle", 32'(guess_ready), 32'd0);

    // Random traffic, guesses biased towards the stored code.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        se = ($urandom_range(0, 7) == 0);
        sc = 4'($urandom_range(0, 15));
        gv = ($urandom_range(0, 2) == 0);
        gc = ($urandom_range(0, 1) == 0) ? 4'(code) : 4'($urandom_range(0, 15));
        rl = ($urandom_range(0, 3) == 0);
        step(se, sc, gv, gc, rl);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/auth_ctrl.md
AUTH_CTRL -- requirements
Module: auth_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 3, consecutive failed guesses before lockout; legal range 1..3.
REQ-002 Parameter LOCKOUT_CYCLES, default 16, lockout duration in clock cycles; legal range 1..255.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 set_en  input  1  request to load set_code as the stored code.
REQ-007 set_code  input  4  code value to store (setter bits s1..s4, s1 = bit 3).
REQ-008 guess_valid  input  1  guess submit button; qualifies guess_code.
REQ-009 guess_code  input  4  guessed code (guesser bits g1..g4, g1 = bit 3).
REQ-010 relock  input  1  return from OPEN to ARMED.
REQ-011 guess_ready  output  1  high exactly when state is ARMED.
REQ-012 matched  output  1  one-cycle pulse: accepted guess equalled stored code.
REQ-013 unmatched  output  1  one-cycle pulse: accepted guess differed from stored code.
REQ-014 locked  output  1  high exactly while state is LOCKOUT.
REQ-015 is_open  output  1  high exactly while state is OPEN.
REQ-016 attempts_left  output  2  MAX_TRIES minus current consecutive failure count.

Function
REQ-017 FSM states SHALL be IDLE, ARMED, CHECK, OPEN, LOCKOUT; all transitions on rising clk.
REQ-018 IDLE: no code stored; set_en -> store set_code, go ARMED; guess_valid and relock ignored.
REQ-019 ARMED: guess_valid -> capture guess_code into guess register, go CHECK; set_en and relock ignored.
REQ-020 Guess handshake: guess accepted only on an edge where guess_valid=1 and guess_ready=1; otherwise dropped, no pulse.
REQ-021 CHECK lasts exactly one cycle; comparison is bitwise equality on all 4 bits (all four XNORs true).
REQ-022 CHECK match: matched=1 for the following cycle, failure count -> 0, go OPEN.
REQ-023 CHECK mismatch, count+1 < MAX_TRIES: unmatched=1 for following cycle, count+1, go ARMED.
REQ-024 CHECK mismatch, count+1 = MAX_TRIES: unmatched=1 for following cycle, load timer with LOCKOUT_CYCLES, go LOCKOUT.
REQ-025 Latency: guess accepted at edge k -> matched/unmatched high between edges k+1 and k+2; never both high.
REQ-026 LOCKOUT: timer decrements each cycle; locked high exactly LOCKOUT_CYCLES cycles; at expiry count -> 0, go ARMED; all inputs ignored.
REQ-027 OPEN: set_en -> store new set_code, go ARMED; else relock -> go ARMED; guess_valid ignored.
REQ-028 OPEN with set_en and relock simultaneous: set_en takes priority (code updated), go ARMED.
REQ-029 attempts_left = MAX_TRIES in IDLE/OPEN and after lockout; reads 0 throughout LOCKOUT.
REQ-030 Stored code SHALL change only via REQ-018 or REQ-027.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, stored code 0, guess register 0, failure count 0, timer 0.
REQ-032 During reset: guess_ready=0, matched=0, unmatched=0, locked=0, is_open=0, attempts_left=MAX_TRIES.
REQ-033 Reset asserted in any state, including CHECK or LOCKOUT, SHALL drop pending result pulse and timer.
REQ-034 First edge after reset release SHALL act per IDLE rules.

Verification
REQ-035 Reset, set_en with set_code=4'b1010, guess 4'b1010 -> guess_ready 1 after set, matched pulse 1 cycle at k+1, is_open=1, attempts_left=3.
REQ-036 Code 4'b0110, guesses 4'b0111, 4'b0100 -> two unmatched pulses, attempts_left 2 then 1, state ARMED; third guess 4'b0110 -> matched, attempts_left=3.
REQ-037 Code 4'b1111, three wrong guesses -> unmatched on third, locked high exactly 16 cycles, guess_valid during lockout ignored, then ARMED with attempts_left=3.
REQ-038 IDLE: guess_valid with guess_code=4'b0000 -> no pulse, state IDLE; ARMED: set_en with 4'b0001 -> stored code unchanged.
REQ-039 OPEN: set_en=1 and relock=1 same cycle with set_code=4'b0011 -> ARMED; guess 4'b0011 -> matched.
REQ-040 Assert rst during LOCKOUT cycle 5 and during CHECK -> all outputs 0 immediately, attempts_left=3, IDLE after release.
